// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM skid stage: control bundle layout,
// skid buffer state encoding and the packed payload width.
package pipe_pkg;

    // Bit positions of the M/WB control bundle
    localparam int BEQ      = 0;
    localparam int BNE      = 1;
    localparam int MEMREAD  = 2;
    localparam int MEMWRITE = 3;
    localparam int MEMTOREG = 4;
    localparam int REGWRITE = 5;
    localparam int CTRL_W   = 6;

    // Occupancy of the 2-entry skid buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Packed payload: control bundle, ALU result, zero flag, branch target,
    // store data and destination register
    function automatic int payload_w(input int data_w, input int reg_addr_w);
        return CTRL_W + 3 * data_w + 1 + reg_addr_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush. The main entry drives
// the output; the skid entry catches the one accept that can slip in while
// the main entry is blocked. in_ready is a register so it never depends
// combinationally on out_ready.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state_r;
    skid_state_t  state_nxt_s;
    logic         ready_r;
    logic         valid_r;
    logic [W-1:0] main_r;
    logic [W-1:0] skid_r;
    logic         accept_s;
    logic         drain_s;
    logic         load_main_in_s;
    logic         load_main_skid_s;
    logic         load_skid_s;

    assign accept_s  = in_valid & ready_r;
    assign drain_s   = valid_r & out_ready;
    assign in_ready  = ready_r;
    assign out_valid = valid_r;
    assign out_data  = main_r;

    // Next-state and entry-load decode; flush overrides accept and drain
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s    = ONE;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && !drain_s) begin
                        state_nxt_s = FULL;
                        load_skid_s = 1'b1;
                    end else if (accept_s && drain_s) begin
                        state_nxt_s    = ONE;
                        load_main_in_s = 1'b1;
                    end else if (drain_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                FULL: begin
                    if (drain_s) begin
                        state_nxt_s      = ONE;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // State, registered handshake flags and entry storage
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= EMPTY;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            main_r  <= {W{1'b0}};
            skid_r  <= {W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s != FULL);
            valid_r <= (state_nxt_s != EMPTY);
            if (load_main_in_s) begin
                main_r <= in_data;
            end else if (load_main_skid_s) begin
                main_r <= skid_r;
            end else begin
                main_r <= main_r;
            end
            if (load_skid_s) begin
                skid_r <= in_data;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline stage: packs the EX outputs into one payload, carries it
// through a 2-entry skid buffer, masks control bits on bubbles, resolves
// branch-taken for MEM and counts back-pressure cycles.
module ex_mem_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int STAT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_beq,
    input  logic                  in_bne,
    input  logic                  in_memread,
    input  logic                  in_memwrite,
    input  logic                  in_memtoreg,
    input  logic                  in_regwrite,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic                  in_alu_zero,
    input  logic [DATA_W-1:0]     in_branch_target,
    input  logic [DATA_W-1:0]     in_read_data2,
    input  logic [REG_ADDR_W-1:0] in_write_reg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_beq,
    output logic                  out_bne,
    output logic                  out_memread,
    output logic                  out_memwrite,
    output logic                  out_memtoreg,
    output logic                  out_regwrite,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic                  out_alu_zero,
    output logic [DATA_W-1:0]     out_branch_target,
    output logic [DATA_W-1:0]     out_read_data2,
    output logic [REG_ADDR_W-1:0] out_write_reg,
    output logic                  out_branch_taken,
    output logic [STAT_W-1:0]     stall_count
);

    localparam int P = payload_w(DATA_W, REG_ADDR_W);
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    logic [CTRL_W-1:0] ctrl_in_s;
    logic [CTRL_W-1:0] ctrl_main_s;
    logic [CTRL_W-1:0] ctrl_out_s;
    logic [P-1:0]      payload_in_s;
    logic [P-1:0]      payload_out_s;
    logic              valid_s;
    logic [STAT_W-1:0] stall_r;

    assign ctrl_in_s[BEQ]      = in_beq;
    assign ctrl_in_s[BNE]      = in_bne;
    assign ctrl_in_s[MEMREAD]  = in_memread;
    assign ctrl_in_s[MEMWRITE] = in_memwrite;
    assign ctrl_in_s[MEMTOREG] = in_memtoreg;
    assign ctrl_in_s[REGWRITE] = in_regwrite;

    assign payload_in_s = {ctrl_in_s, in_alu_result, in_alu_zero,
                           in_branch_target, in_read_data2, in_write_reg};

    pipe_skid_buf #(
        .W (P)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (payload_in_s),
        .out_valid (valid_s),
        .out_ready (out_ready),
        .out_data  (payload_out_s)
    );

    assign {ctrl_main_s, out_alu_result, out_alu_zero,
            out_branch_target, out_read_data2, out_write_reg} = payload_out_s;

    // Bubbles must never issue a memory access or register write downstream
    always_comb begin
        ctrl_out_s = {CTRL_W{1'b0}};
        if (valid_s) begin
            ctrl_out_s = ctrl_main_s;
        end else begin
            ctrl_out_s = {CTRL_W{1'b0}};
        end
    end

    assign out_valid        = valid_s;
    assign out_beq          = ctrl_out_s[BEQ];
    assign out_bne          = ctrl_out_s[BNE];
    assign out_memread      = ctrl_out_s[MEMREAD];
    assign out_memwrite     = ctrl_out_s[MEMWRITE];
    assign out_memtoreg     = ctrl_out_s[MEMTOREG];
    assign out_regwrite     = ctrl_out_s[REGWRITE];
    assign out_branch_taken = (ctrl_out_s[BEQ] & out_alu_zero) |
                              (ctrl_out_s[BNE] & ~out_alu_zero);
    assign stall_count      = stall_r;

    // Saturating count of cycles where MEM holds off a valid entry
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_r <= {STAT_W{1'b0}};
        end else if (valid_s && !out_ready && (stall_r != STAT_MAX)) begin
            stall_r <= stall_r + STAT_W'(1);
        end else begin
            stall_r <= stall_r;
        end
    end

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Directed bench for ex_mem_skid_stage with a scoreboard queue and an
// independent output monitor.
module tb_ex_mem_skid_stage;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int STAT_W     = 4;

    localparam logic [5:0] C_BEQ = 6'b000001;
    localparam logic [5:0] C_BNE = 6'b000010;
    localparam logic [5:0] C_MR  = 6'b000100;
    localparam logic [5:0] C_MW  = 6'b001000;
    localparam logic [5:0] C_M2R = 6'b010000;
    localparam logic [5:0] C_RW  = 6'b100000;

    typedef struct packed {
        logic [5:0]  ctrl;
        logic [31:0] alu;
        logic        zero;
        logic [31:0] tgt;
        logic [31:0] rd2;
        logic [4:0]  wr;
        logic        bt;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic                  in_beq, in_bne, in_memread, in_memwrite, in_memtoreg, in_regwrite;
    logic                  out_beq, out_bne, out_memread, out_memwrite, out_memtoreg, out_regwrite;
    logic [DATA_W-1:0]     in_alu_result, in_branch_target, in_read_data2;
    logic [DATA_W-1:0]     out_alu_result, out_branch_target, out_read_data2;
    logic                  in_alu_zero, out_alu_zero, out_branch_taken;
    logic [REG_ADDR_W-1:0] in_write_reg, out_write_reg;
    logic [STAT_W-1:0]     stall_count;
    logic [5:0]            out_ctrl;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    assign out_ctrl = {out_regwrite, out_memtoreg, out_memwrite, out_memread, out_bne, out_beq};

    ex_mem_skid_stage #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .STAT_W     (STAT_W)
    ) dut (
        .clk (clk), .reset (reset), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready),
        .in_beq (in_beq), .in_bne (in_bne), .in_memread (in_memread),
        .in_memwrite (in_memwrite), .in_memtoreg (in_memtoreg), .in_regwrite (in_regwrite),
        .in_alu_result (in_alu_result), .in_alu_zero (in_alu_zero),
        .in_branch_target (in_branch_target), .in_read_data2 (in_read_data2),
        .in_write_reg (in_write_reg),
        .out_valid (out_valid), .out_ready (out_ready),
        .out_beq (out_beq), .out_bne (out_bne), .out_memread (out_memread),
        .out_memwrite (out_memwrite), .out_memtoreg (out_memtoreg), .out_regwrite (out_regwrite),
        .out_alu_result (out_alu_result), .out_alu_zero (out_alu_zero),
        .out_branch_target (out_branch_target), .out_read_data2 (out_read_data2),
        .out_write_reg (out_write_reg), .out_branch_taken (out_branch_taken),
        .stall_count (stall_count)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t ent(input logic [5:0] c, input logic [31:0] a, input logic z,
                                 input logic [31:0] t, input logic [31:0] d,
                                 input logic [4:0] w, input logic bt);
        exp_t e;
        e.ctrl = c; e.alu = a; e.zero = z; e.tgt = t; e.rd2 = d; e.wr = w; e.bt = bt;
        return e;
    endfunction

    task automatic drive(input exp_t e);
        in_valid         = 1'b1;
        {in_regwrite, in_memtoreg, in_memwrite, in_memread, in_bne, in_beq} = e.ctrl;
        in_alu_result    = e.alu;
        in_alu_zero      = e.zero;
        in_branch_target = e.tgt;
        in_read_data2    = e.rd2;
        in_write_reg     = e.wr;
    endtask

    task automatic issue(input exp_t e);
        drive(e);
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_out_valid"}, {127'd0, out_valid}, 128'd0);
        chk({tag, "_in_ready"}, {127'd0, in_ready}, 128'd1);
        chk({tag, "_ctrl"}, {122'd0, out_ctrl}, 128'd0);
        chk({tag, "_branch_taken"}, {127'd0, out_branch_taken}, 128'd0);
        chk({tag, "_stall_count"}, {124'd0, stall_count}, 128'd0);
        chk({tag, "_data"}, {31'd0, out_alu_result, out_alu_zero, out_branch_target,
                             out_read_data2, out_write_reg}, 128'd0);
    endtask

    // Output monitor: every transfer on the MEM side is checked against the queue
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got alu 0x%0h, required no entry", out_alu_result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("output_entry",
                    {19'd0, out_ctrl, out_alu_result, out_alu_zero, out_branch_target,
                     out_read_data2, out_write_reg, out_branch_taken},
                    {19'd0, e});
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        exp_t es [4];
        exp_t ea, eb, ec, junk;

        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0;
        drive(ent(6'd0, 32'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0));
        in_valid = 1'b0;
        step(); step();
        @(negedge clk);
        check_reset_vals("reset");

        // Streaming with out_ready high: branch resolution and full-width target
        step();
        reset = 1'b0; out_ready = 1'b1;
        es[0] = ent(C_BEQ,              32'h10, 1'b1, 32'h100,      32'hA0, 5'd1,  1'b1);
        es[1] = ent(C_BNE,              32'h20, 1'b1, 32'h200,      32'hB0, 5'd2,  1'b0);
        es[2] = ent(C_BNE | C_MW,       32'h30, 1'b0, 32'h300,      32'hC0, 5'd3,  1'b1);
        es[3] = ent(C_BEQ | C_RW | C_MR | C_M2R, 32'h40, 1'b1, 32'hFFFF_FFFC, 32'hD0, 5'd31, 1'b1);
        for (int i = 0; i < 4; i++) begin
            issue(es[i]);
            @(negedge clk);
            chk("stream_in_ready", {127'd0, in_ready}, 128'd1);
            if (i > 0) chk("stream_out_valid", {127'd0, out_valid}, 128'd1);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last_valid", {127'd0, out_valid}, 128'd1);
        chk("stream_full_target", {96'd0, out_branch_target}, {96'd0, 32'hFFFF_FFFC});
        step();
        @(negedge clk);
        chk("bubble_valid", {127'd0, out_valid}, 128'd0);
        chk("bubble_ctrl", {122'd0, out_ctrl}, 128'd0);
        chk("bubble_branch_taken", {127'd0, out_branch_taken}, 128'd0);

        // Back-pressure: A in main, B into skid, C held off
        step();
        ea = ent(C_RW,        32'h11, 1'b0, 32'h1000, 32'h1111, 5'd4, 1'b0);
        eb = ent(C_MW,        32'h22, 1'b1, 32'h2000, 32'h2222, 5'd5, 1'b0);
        ec = ent(C_BNE | C_MR, 32'h33, 1'b0, 32'h3000, 32'h3333, 5'd6, 1'b1);
        issue(ea);
        @(negedge clk);
        chk("bp_c0_in_ready", {127'd0, in_ready}, 128'd1);
        step();
        issue(eb); out_ready = 1'b0;
        @(negedge clk);
        chk("bp_c1_out_valid", {127'd0, out_valid}, 128'd1);
        chk("bp_c1_in_ready", {127'd0, in_ready}, 128'd1);
        step();
        issue(ec);
        @(negedge clk);
        chk("bp_c2_in_ready", {127'd0, in_ready}, 128'd0);
        chk("bp_c2_stall", {124'd0, stall_count}, 128'd1);
        step();
        @(negedge clk);
        chk("bp_c3_in_ready", {127'd0, in_ready}, 128'd0);
        chk("bp_c3_stall", {124'd0, stall_count}, 128'd2);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_c4_stall", {124'd0, stall_count}, 128'd3);
        chk("bp_c4_in_ready", {127'd0, in_ready}, 128'd0);
        step();
        @(negedge clk);
        chk("bp_c5_in_ready", {127'd0, in_ready}, 128'd1);
        chk("bp_c5_out_valid", {127'd0, out_valid}, 128'd1);
        chk("bp_c5_stall", {124'd0, stall_count}, 128'd3);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_c6_out_valid", {127'd0, out_valid}, 128'd1);
        step();
        @(negedge clk);
        chk("bp_c7_out_valid", {127'd0, out_valid}, 128'd0);
        chk("bp_queue_drained", 128'(sb_q.size()), 128'd0);

        // Flush in FULL with an offered entry, then flush in ONE with an accept
        junk = ent(6'b111111, 32'hDEAD_0000, 1'b1, 32'hBAD0, 32'hBAD1, 5'd9, 1'b1);
        step();
        out_ready = 1'b0;
        drive(junk);
        step();
        junk.alu = 32'hDEAD_0001; drive(junk);
        @(negedge clk);
        chk("fl_c1_in_ready", {127'd0, in_ready}, 128'd1);
        step();
        junk.alu = 32'hDEAD_0002; drive(junk); flush = 1'b1;
        @(negedge clk);
        chk("fl_full_in_ready", {127'd0, in_ready}, 128'd0);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("fl_full_out_valid", {127'd0, out_valid}, 128'd0);
        chk("fl_full_ctrl", {122'd0, out_ctrl}, 128'd0);
        chk("fl_full_branch_taken", {127'd0, out_branch_taken}, 128'd0);
        chk("fl_full_in_ready_after", {127'd0, in_ready}, 128'd1);
        step();
        @(negedge clk);
        chk("fl_full_no_leak", {127'd0, out_valid}, 128'd0);
        step();
        out_ready = 1'b0;
        junk.alu = 32'hDEAD_0003; drive(junk);
        step();
        junk.alu = 32'hDEAD_0004; drive(junk); flush = 1'b1;
        @(negedge clk);
        chk("fl_one_out_valid_before", {127'd0, out_valid}, 128'd1);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("fl_one_out_valid", {127'd0, out_valid}, 128'd0);
        chk("fl_one_in_ready", {127'd0, in_ready}, 128'd1);
        step();
        @(negedge clk);
        chk("fl_one_accept_dropped", {127'd0, out_valid}, 128'd0);

        // Stall counter saturation, then reset (with flush) mid-FULL
        step();
        reset = 1'b1; out_ready = 1'b0;
        step();
        reset = 1'b0;
        junk.alu = 32'hDEAD_0005; drive(junk);
        step();
        junk.alu = 32'hDEAD_0006; drive(junk);
        step();
        in_valid = 1'b0;
        repeat (13) step();
        @(negedge clk);
        chk("sat_stall_14", {124'd0, stall_count}, 128'd14);
        repeat (6) step();
        @(negedge clk);
        chk("sat_stall_15", {124'd0, stall_count}, 128'd15);
        chk("sat_full_in_ready", {127'd0, in_ready}, 128'd0);
        step();
        reset = 1'b1; flush = 1'b1;
        junk.alu = 32'hDEAD_0007; drive(junk);
        step();
        @(negedge clk);
        check_reset_vals("mid_full_reset");
        step();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("post_reset_out_valid", {127'd0, out_valid}, 128'd0);
        chk("post_reset_stall", {124'd0, stall_count}, 128'd0);
        chk("final_queue_empty", 128'(sb_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
